// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch control sequencer: FSM state
// encoding and the helpers that size the tick prescaler from the clock
// and tick rates.
package stopwatch_pkg;

  // FSM state encoding. These values are visible on the state output.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_LAP   = 2'b10,
    ST_PAUSE = 2'b11
  } sw_state_e;

  // Number of clk cycles per counter increment.
  function automatic int unsigned tick_div_f(input int unsigned clk_hz,
                                             input int unsigned tick_hz);
    return clk_hz / tick_hz;
  endfunction

  // Prescaler width able to hold 0..div-1. Never narrower than one bit.
  function automatic int unsigned presc_w_f(input int unsigned div);
    return (div <= 2) ? 1 : $clog2(div);
  endfunction

  // The counter advances only while running, with or without lap hold.
  function automatic logic is_counting(input sw_state_e s);
    return (s == ST_RUN) || (s == ST_LAP);
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Front-panel button conditioner: 2-FF synchronizer, stable-count
// debouncer and rising-edge detector producing a one-cycle press pulse.
// Release edges never produce a pulse.
//
// Build option STOPWATCH_DEBOUNCE_EN:
//   defined   - debouncer present; raw edge to press = 2 + DEBOUNCE_CYCLES + 1
//   undefined - debouncer bypassed; press taken from the synchronizer output
//               (raw edge to press = 3) and DEBOUNCE_CYCLES is ignored.
module btn_debounce
  import stopwatch_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 500_000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic press
);

  logic sync1;
  logic sync2;
  logic level;
  logic level_d;

  // Two-flop synchronizer for the asynchronous raw button.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
    end
  end

`ifdef STOPWATCH_DEBOUNCE_EN
  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);

  logic [CNT_W-1:0] stable_cnt;
  logic             accepted;

  // Count consecutive samples that disagree with the accepted level; any
  // sample that agrees again restarts the count. The new level is taken
  // on the DEBOUNCE_CYCLES-th consecutive differing sample.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stable_cnt <= '0;
      accepted   <= 1'b0;
    end else if (sync2 == accepted) begin
      stable_cnt <= '0;
    end else if (stable_cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
      stable_cnt <= '0;
      accepted   <= sync2;
    end else begin
      stable_cnt <= stable_cnt + 1'b1;
    end
  end

  assign level = accepted;
`else
  assign level = sync2;
`endif

  // Previous accepted level, for rising-edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level_d <= 1'b0;
    end else begin
      level_d <= level;
    end
  end

  // Press is combinational off the accepted level so the FSM consumes it
  // on the very next edge.
  assign press = level & ~level_d;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control sequencer. Conditions the start/stop and lap/clear
// buttons, runs the IDLE/RUN/LAP/PAUSE machine, generates the count-enable
// tick and clear pulse for the 0-9999 BCD counter, and drives the display
// freeze level used for lap hold.
//
// Build option STOPWATCH_DEBOUNCE_EN selects whether the button debouncers
// are present (see btn_debounce).
//
// Handshake: there is none. count_en and count_clr are single-cycle
// strobes the counter must act on in the cycle they are high; at_max is a
// level from the counter sampled every cycle. The strobes are never high
// together.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int unsigned CLK_HZ          = 50_000_000,
  parameter int unsigned TICK_HZ         = 1000,
  parameter int unsigned DEBOUNCE_CYCLES = 500_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_start,
  input  logic       btn_lap,
  input  logic       at_max,
  output logic       count_en,
  output logic       count_clr,
  output logic       disp_freeze,
  output logic [1:0] state
);

  localparam int unsigned TICK_DIV = tick_div_f(CLK_HZ, TICK_HZ);
  localparam int unsigned PRESC_W  = presc_w_f(TICK_DIV);

  sw_state_e          state_q;
  sw_state_e          state_d;
  logic               start_press;
  logic               lap_press;
  logic               s_press;
  logic               l_press;
  logic [PRESC_W-1:0] presc;
  logic               tick;
  logic               en_d;
  logic               clr_d;
  logic               frz_d;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_start_btn (
    .clk  (clk),
    .rst  (rst),
    .btn  (btn_start),
    .press(start_press)
  );

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_lap_btn (
    .clk  (clk),
    .rst  (rst),
    .btn  (btn_lap),
    .press(lap_press)
  );

  // A start press in the same cycle as a lap press wins; the lap is dropped.
  assign s_press = start_press;
  assign l_press = lap_press & ~start_press;

  // Tick prescaler: runs only while counting and restarts from zero on
  // every resume, so the first increment always comes a full period later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc <= '0;
    end else if (!is_counting(state_q)) begin
      presc <= '0;
    end else if (presc == PRESC_W'(TICK_DIV - 1)) begin
      presc <= '0;
    end else begin
      presc <= presc + 1'b1;
    end
  end

  assign tick = is_counting(state_q) && (presc == PRESC_W'(TICK_DIV - 1));

  // State register, with the strobes and freeze level registered alongside.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      count_en    <= 1'b0;
      count_clr   <= 1'b0;
      disp_freeze <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_en    <= en_d;
      count_clr   <= clr_d;
      disp_freeze <= frz_d;
    end
  end

  // Next-state logic: start press first, then lap press, then saturation.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (s_press) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (s_press)      state_d = ST_PAUSE;
        else if (l_press) state_d = ST_LAP;
        else if (at_max)  state_d = ST_PAUSE;
      end
      ST_LAP: begin
        if (s_press)      state_d = ST_PAUSE;
        else if (l_press) state_d = ST_RUN;
        else if (at_max)  state_d = ST_PAUSE;
      end
      ST_PAUSE: begin
        if (s_press) begin
          if (!at_max) state_d = ST_RUN;
        end else if (l_press) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output logic: clear only from IDLE/PAUSE and increment only from
  // RUN/LAP, so the two strobes can never coincide.
  always_comb begin
    clr_d = l_press && ((state_q == ST_IDLE) || (state_q == ST_PAUSE));
    en_d  = tick && !at_max;
    frz_d = (state_d == ST_LAP);
  end

  assign state = state_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl with CLK_HZ=100, TICK_HZ=10, DEBOUNCE_CYCLES=4.
// Expected state/freeze pairs are queued when a button or at_max stimulus
// is driven and popped when the state change is due; a negedge monitor
// tracks count_en spacing, count_clr pulses and the freeze/LAP relation.
module tb_stopwatch_ctrl;

  localparam int unsigned CLK_HZ   = 100;
  localparam int unsigned TICK_HZ  = 10;
  localparam int unsigned DEB      = 4;
  localparam int unsigned TICK_DIV = 10;
`ifdef STOPWATCH_DEBOUNCE_EN
  localparam int LAT = 2 + DEB + 1;
`else
  localparam int LAT = 3;
`endif

  localparam logic [1:0] IDLE  = 2'b00;
  localparam logic [1:0] RUN   = 2'b01;
  localparam logic [1:0] LAP   = 2'b10;
  localparam logic [1:0] PAUSE = 2'b11;

  logic       clk = 1'b0;
  logic       rst;
  logic       btn_start;
  logic       btn_lap;
  logic       at_max;
  logic       count_en;
  logic       count_clr;
  logic       disp_freeze;
  logic [1:0] state;

  int vectors     = 0;
  int miscompares = 0;
  int en_cnt      = 0;
  int clr_cnt     = 0;
  int cyc_n       = 0;
  int last_mark   = 0;
  logic [1:0] prev_state = IDLE;

  logic [2:0] exp_q[$];

  stopwatch_ctrl #(
    .CLK_HZ         (CLK_HZ),
    .TICK_HZ        (TICK_HZ),
    .DEBOUNCE_CYCLES(DEB)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .btn_start  (btn_start),
    .btn_lap    (btn_lap),
    .at_max     (at_max),
    .count_en   (count_en),
    .count_clr  (count_clr),
    .disp_freeze(disp_freeze),
    .state      (state)
  );

  // Clock and reset timing
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Monitor: count strobes, check tick spacing and invariants each cycle.
  always @(negedge clk) begin
    if (rst) begin
      prev_state = IDLE;
    end else begin
      cyc_n++;
      if (count_en) begin
        en_cnt++;
        check("en_gap", cyc_n - last_mark, TICK_DIV);
        last_mark = cyc_n;
      end
      if (count_clr) clr_cnt++;
      if ((state == RUN || state == LAP) && !(prev_state == RUN || prev_state == LAP))
        last_mark = cyc_n;
      check("en_clr_excl", {31'd0, count_en & count_clr}, 32'd0);
      check("frz_is_lap", {31'd0, disp_freeze}, {31'd0, state == LAP});
      prev_state = state;
    end
  end

  // Driver helpers; every task starts and ends 1 ns after a rising edge.
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [1:0] st);
    exp_q.push_back({st, st == LAP});
  endtask

  task automatic pop_check(input string tag);
    logic [2:0] e;
    check({tag, "_qdepth"}, exp_q.size(), 1);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check(tag, {29'd0, state, disp_freeze}, {29'd0, e});
    end
  endtask

  task automatic press(input string tag, input logic s, input logic l,
                       input logic [1:0] from_st, input logic [1:0] to_st);
    push_exp(to_st);
    btn_start = s;
    btn_lap   = l;
    cyc(LAT - 1);
    check({tag, "_pre"}, {30'd0, state}, {30'd0, from_st});
    cyc(1);
    pop_check(tag);
    btn_start = 1'b0;
    btn_lap   = 1'b0;
  endtask

  int base_en;
  int base_clr;

  initial begin
    rst       = 1'b1;
    btn_start = 1'b0;
    btn_lap   = 1'b0;
    at_max    = 1'b0;
    cyc(3);
    check("rst_state", {30'd0, state}, {30'd0, IDLE});
    check("rst_en", {31'd0, count_en}, 32'd0);
    check("rst_clr", {31'd0, count_clr}, 32'd0);
    check("rst_frz", {31'd0, disp_freeze}, 32'd0);
    #2 rst = 1'b0;
    cyc(3);
    check("idle_state", {30'd0, state}, {30'd0, IDLE});
    check("rel_no_clr", clr_cnt, 0);

`ifdef STOPWATCH_DEBOUNCE_EN
    // Short glitch must be rejected by the debouncer.
    btn_start = 1'b1;
    cyc(3);
    btn_start = 1'b0;
    cyc(15);
    check("glitch_state", {30'd0, state}, {30'd0, IDLE});
    check("glitch_en", en_cnt, 0);
`endif

    // Run, lap hold, lap release; ticks continue throughout.
    base_en = en_cnt;
    press("start", 1'b1, 1'b0, IDLE, RUN);
    cyc(35);
    press("lap1", 1'b0, 1'b1, RUN, LAP);
    cyc(30);
    press("lap2", 1'b0, 1'b1, LAP, RUN);
    check("run_en_cnt", en_cnt - base_en, (64 + 2 * LAT) / 10);

    // Pause: no increments; lap clears once and returns to IDLE.
    cyc(12);
    press("pause", 1'b1, 1'b0, RUN, PAUSE);
    cyc(3);
    base_en = en_cnt;
    cyc(25);
    check("pause_no_en", en_cnt - base_en, 0);
    base_clr = clr_cnt;
    press("clr", 1'b0, 1'b1, PAUSE, IDLE);
    cyc(3);
    check("clr_once", clr_cnt - base_clr, 1);

    // Lap in IDLE clears and stays IDLE.
    cyc(10);
    base_clr = clr_cnt;
    press("idle_clr", 1'b0, 1'b1, IDLE, IDLE);
    cyc(3);
    check("idle_clr_once", clr_cnt - base_clr, 1);

    // Saturation in RUN: pause, no further ticks, start refused.
    cyc(10);
    base_clr = clr_cnt;
    press("start2", 1'b1, 1'b0, IDLE, RUN);
    cyc(15);
    check("start2_no_clr", clr_cnt - base_clr, 0);
    push_exp(PAUSE);
    at_max = 1'b1;
    cyc(1);
    pop_check("atmax_pause");
    base_en = en_cnt;
    cyc(25);
    check("atmax_no_en", en_cnt - base_en, 0);
    press("atmax_start", 1'b1, 1'b0, PAUSE, PAUSE);
    cyc(10);
    press("atmax_clr", 1'b0, 1'b1, PAUSE, IDLE);
    at_max = 1'b0;
    cyc(10);

    // Saturation in LAP releases the freeze.
    press("start3", 1'b1, 1'b0, IDLE, RUN);
    cyc(10);
    press("lap3", 1'b0, 1'b1, RUN, LAP);
    cyc(5);
    push_exp(PAUSE);
    at_max = 1'b1;
    cyc(1);
    pop_check("lap_atmax");
    cyc(10);
    press("lap_atmax_clr", 1'b0, 1'b1, PAUSE, IDLE);
    at_max = 1'b0;
    cyc(10);

    // Simultaneous start and lap from IDLE: start wins, no clear.
    base_clr = clr_cnt;
    press("both", 1'b1, 1'b1, IDLE, RUN);
    cyc(3);
    check("both_no_clr", clr_cnt - base_clr, 0);

    // Asynchronous reset while in lap hold.
    cyc(10);
    press("lap4", 1'b0, 1'b1, RUN, LAP);
    cyc(13);
    #2 rst = 1'b1;
    #1;
    check("arst_state", {30'd0, state}, {30'd0, IDLE});
    check("arst_en", {31'd0, count_en}, 32'd0);
    check("arst_clr", {31'd0, count_clr}, 32'd0);
    check("arst_frz", {31'd0, disp_freeze}, 32'd0);
    @(posedge clk);
    #3 rst = 1'b0;
    base_clr = clr_cnt;
    base_en  = en_cnt;
    cyc(15);
    check("post_rst_state", {30'd0, state}, {30'd0, IDLE});
    check("post_rst_no_clr", clr_cnt - base_clr, 0);
    check("post_rst_no_en", en_cnt - base_en, 0);
    check("exp_q_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
